rect_list_drawer: RTL and testbench

Parametrised successor to the fixed end-of-game bar renderer. It walks a table of NUM_RECTS rectangle descriptors held in an external synchronous ROM. Each rectangle is rasterised as one pixel per clock onto the VGA adapter's plot/x/y/colour port. Per-run erase mode, per-pixel screen clipping, a hold (stall) input and a start/busy/done handshake let the game FSM reuse the block for the title, game-over and level screens.

---
 rtl/draw_pkg.sv | 34 +++
 rtl/rect_raster.sv | 103 ++++++++++
 rtl/rect_list_drawer.sv | 124 ++++++++++++
 tb/tb_rect_list_drawer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and screen constants for the rectangle list drawer.
// Contents: run-state enum, ROM descriptor record, default screen limits.
// Included by rect_list_drawer and rect_raster.
package draw_pkg;

  // Run sequencing states of the drawer FSM.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    DRAW,
    NEXT,
    DONE
  } state_t;

  // Default field widths of one ROM descriptor (match the VGA adapter).
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOUR_W = 3;

  // Visible screen area; pixels outside it are clipped when clipping is on.
  localparam int DEF_X_MAX = 160;
  localparam int DEF_Y_MAX = 120;

  // Layout of one rectangle record as stored in the descriptor ROM.
  typedef struct packed {
    logic [DEF_X_W-1:0]      x;
    logic [DEF_Y_W-1:0]      y;
    logic [DEF_X_W-1:0]      w;
    logic [DEF_Y_W-1:0]      h;
    logic [DEF_COLOUR_W-1:0] colour;
  } rect_desc_t;

endpackage

// File: rtl/rect_raster.sv
// Purpose: rasterises one latched rectangle, one pixel per DRAW cycle, with optional clipping.
// Latency: pixel for a stepping cycle is registered on plot/x/y/colour one clock later.
// Backpressure: hold freezes the cx/cy counters and suppresses plot for that cycle.
//
// Ports:
//   clock, reset            - clock, async active-high reset
//   load                    - latch rect_* descriptor and clear counters (FSM in LOAD)
//   draw                    - FSM is in DRAW; one pixel per cycle unless hold
//   hold                    - stall request
//   erase                   - force colour 0 for the whole run
//   rect_x/y/w/h/colour     - descriptor fields from the ROM
//   last_pixel              - combinational, high in the cycle the final pixel is stepped
//   plot, x, y, colour      - registered pixel write port
module rect_raster
  import draw_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int X_MAX    = DEF_X_MAX,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int CLIP     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                draw,
  input  logic                hold,
  input  logic                erase,
  input  logic [X_W-1:0]      rect_x,
  input  logic [Y_W-1:0]      rect_y,
  input  logic [X_W-1:0]      rect_w,
  input  logic [Y_W-1:0]      rect_h,
  input  logic [COLOUR_W-1:0] rect_colour,
  output logic                last_pixel,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  // One extra bit so a limit equal to 2^W (nothing clipped) is representable.
  localparam logic [X_W:0]   X_LIM   = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   Y_LIM   = (Y_W+1)'(Y_MAX);
  localparam logic [X_W-1:0] X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);
  localparam bit             CLIP_EN = (CLIP != 0);

  logic [X_W-1:0]      rx, rw, cx, px;
  logic [Y_W-1:0]      ry, rh, cy, py;
  logic [COLOUR_W-1:0] rcol;
  logic                step;
  logic                clipped;
  logic                row_end;

  assign step    = draw && !hold;
  // Coordinates wrap at the field width; the carry is intentionally dropped.
  assign px      = rx + cx;
  assign py      = ry + cy;
  assign clipped = CLIP_EN && (({1'b0, px} >= X_LIM) || ({1'b0, py} >= Y_LIM));
  assign row_end = (cx == rw - X_ONE);
  assign last_pixel = step && row_end && (cy == rh - Y_ONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx     <= '0;
      ry     <= '0;
      rw     <= '0;
      rh     <= '0;
      rcol   <= '0;
      cx     <= '0;
      cy     <= '0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= 1'b0;
      if (load) begin
        rx   <= rect_x;
        ry   <= rect_y;
        rw   <= rect_w;
        rh   <= rect_h;
        rcol <= rect_colour;
        cx   <= '0;
        cy   <= '0;
      end else if (step) begin
        // A clipped pixel still spends its cycle, it just does not strobe.
        plot   <= !clipped;
        x      <= px;
        y      <= py;
        colour <= erase ? '0 : rcol;
        if (row_end) begin
          cx <= '0;
          cy <= cy + Y_ONE;
        end else begin
          cx <= cx + X_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/rect_list_drawer.sv
// Purpose: walks NUM_RECTS ROM descriptors and rasterises each onto the VGA plot port.
// Latency: start at t -> FETCH t+1, LOAD t+2, first DRAW t+3, first plot t+4; 3+w*h cycles per rect.
// Backpressure: hold stalls pixel stepping in DRAW only; start is ignored unless IDLE.
//
// Ports:
//   clock, reset          - clock, async active-high reset
//   start, erase          - run request (IDLE only) and erase mode sampled with it
//   hold                  - stall rasterisation
//   rect_idx              - ROM read address, valid from FETCH; ROM data expected in LOAD
//   rect_x/y/w/h/colour   - descriptor read back from the synchronous ROM
//   plot, x, y, colour    - registered pixel write port
//   busy, done            - busy FETCH..NEXT, done one-cycle pulse after the final NEXT
module rect_list_drawer
  import draw_pkg::*;
#(
  parameter int NUM_RECTS = 11,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int COLOUR_W  = DEF_COLOUR_W,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int CLIP      = 1,
  localparam int IDX_W    = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                erase,
  input  logic                hold,
  output logic [IDX_W-1:0]    rect_idx,
  input  logic [X_W-1:0]      rect_x,
  input  logic [Y_W-1:0]      rect_y,
  input  logic [X_W-1:0]      rect_w,
  input  logic [Y_W-1:0]      rect_h,
  input  logic [COLOUR_W-1:0] rect_colour,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RECTS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t state;
  logic   erase_q;
  logic   last_pixel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rect_idx <= '0;
      erase_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            erase_q  <= erase;
            rect_idx <= '0;
            busy     <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        // ROM output is valid this cycle; an empty rectangle goes straight to NEXT.
        LOAD: begin
          if ((rect_w == '0) || (rect_h == '0)) state <= NEXT;
          else                                  state <= DRAW;
        end
        DRAW: begin
          if (last_pixel) state <= NEXT;
        end
        NEXT: begin
          if (rect_idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            rect_idx <= rect_idx + IDX_ONE;
            state    <= FETCH;
          end
        end
        // start is not looked at here, so a request in the done cycle is dropped.
        DONE: begin
          state    <= IDLE;
          rect_idx <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rect_raster #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .COLOUR_W (COLOUR_W),
    .X_MAX    (X_MAX),
    .Y_MAX    (Y_MAX),
    .CLIP     (CLIP)
  ) u_raster (
    .clock       (clock),
    .reset       (reset),
    .load        (state == LOAD),
    .draw        (state == DRAW),
    .hold        (hold),
    .erase       (erase_q),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_colour (rect_colour),
    .last_pixel  (last_pixel),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour)
  );

endmodule

// File: tb/tb_rect_list_drawer.sv
// Bench for rect_list_drawer: a 4-entry clipping instance and a 1-entry non-clipping instance,
// each fed by a synchronous ROM model. Pixel streams and done timing are predicted from the
// rectangle list with plain arithmetic.
module tb_rect_list_drawer;
  import draw_pkg::*;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  int n_vec = 0;
  int n_err = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, start1 = 1'b0, erase = 1'b0, hold = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Instance 0: four descriptors, clipping on.
  rect_desc_t tab0 [4];
  rect_desc_t rom0;
  logic [1:0] idx0;
  logic       plot0, busy0, done0;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [2:0] col0;
  always @(posedge clock) rom0 <= tab0[idx0];

  rect_list_drawer #(.NUM_RECTS(4), .CLIP(1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .erase(erase), .hold(hold),
    .rect_idx(idx0), .rect_x(rom0.x), .rect_y(rom0.y), .rect_w(rom0.w), .rect_h(rom0.h),
    .rect_colour(rom0.colour), .plot(plot0), .x(x0), .y(y0), .colour(col0),
    .busy(busy0), .done(done0)
  );

  // Instance 1: single descriptor, clipping off.
  rect_desc_t tab1 [2];
  rect_desc_t rom1;
  logic       idx1;
  logic       plot1, busy1, done1;
  logic [7:0] x1;
  logic [6:0] y1;
  logic [2:0] col1;
  always @(posedge clock) rom1 <= tab1[idx1];

  rect_list_drawer #(.NUM_RECTS(1), .CLIP(0)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .erase(erase), .hold(hold),
    .rect_idx(idx1), .rect_x(rom1.x), .rect_y(rom1.y), .rect_w(rom1.w), .rect_h(rom1.h),
    .rect_colour(rom1.colour), .plot(plot1), .x(x1), .y(y1), .colour(col1),
    .busy(busy1), .done(done1)
  );

  // Output monitors
  pix_t cap0[$], cap1[$];
  int   done0_cnt = 0, done0_cyc = 0, done1_cnt = 0, done1_cyc = 0;
  logic busy_at_done0 = 1'b0;
  always @(negedge clock) begin
    if (plot0) cap0.push_back({x0, y0, col0});
    if (plot1) cap1.push_back({x1, y1, col1});
    if (done0) begin done0_cnt++; done0_cyc = cyc; busy_at_done0 = busy0; end
    if (done1) begin done1_cnt++; done1_cyc = cyc; end
  end

  // Reference model: expected plotted pixels and cycles from start to the done pulse.
  pix_t exp_q[$];
  int   exp_cyc;
  task automatic model(input rect_desc_t t[4], input int n, input bit er, input bit clip);
    int xx, yy;
    exp_q.delete();
    exp_cyc = 1;
    for (int r = 0; r < n; r++) begin
      exp_cyc += 3 + int'(t[r].w) * int'(t[r].h);
      for (int j = 0; j < int'(t[r].h); j++)
        for (int i = 0; i < int'(t[r].w); i++) begin
          xx = (int'(t[r].x) + i) % 256;
          yy = (int'(t[r].y) + j) % 128;
          if (!clip || (xx < 160 && yy < 120))
            exp_q.push_back({xx[7:0], yy[6:0], er ? 3'd0 : t[r].colour});
        end
    end
  endtask

  function automatic int first_diff(input bit which);
    int n;
    n = which ? cap1.size() : cap0.size();
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      pix_t g;
      g = which ? cap1[i] : cap0[i];
      if (g !== exp_q[i]) return i;
    end
    if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
    return -1;
  endfunction

  function automatic rect_desc_t mk(input int x, input int y, input int w, input int h, input int c);
    rect_desc_t r;
    r.x = 8'(x); r.y = 7'(y); r.w = 8'(w); r.h = 7'(h); r.colour = 3'(c);
    return r;
  endfunction

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  // One run on an instance; optionally raises hold for 5 cycles once hold_after plots are seen.
  task automatic run(input bit which, input bit er, input int hold_after,
                     output int t0, output logic bsy_first);
    if (which) begin cap1.delete(); done1_cnt = 0; end
    else begin cap0.delete(); done0_cnt = 0; end
    erase = er;
    if (which) start1 = 1'b1; else start = 1'b1;
    t0 = cyc;
    tick;
    start = 1'b0; start1 = 1'b0;
    bsy_first = which ? busy1 : busy0;
    if (hold_after >= 0) begin
      for (int k = 0; k < 5000 && cap0.size() < hold_after; k++) tick;
      hold = 1'b1;
      repeat (5) tick;
      hold = 1'b0;
    end
    for (int k = 0; k < 20000 && (which ? done1_cnt : done0_cnt) == 0; k++) tick;
    repeat (4) tick;
  endtask

  task automatic set_basic;
    tab0[0] = mk(40, 40, 4, 26, 3);
    tab0[1] = mk(70, 40, 8, 41, 3);
    tab0[2] = mk(0, 0, 0, 5, 1);
    tab0[3] = mk(10, 10, 5, 0, 2);
  endtask

  task automatic test_reset;
    repeat (3) tick;
    n_vec++;
    if ({plot0, x0, y0, col0, busy0, done0, idx0} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %b want all zero", {plot0, x0, y0, col0, busy0, done0, idx0});
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    int t0, d; logic b;
    set_basic;
    model(tab0, 4, 1'b0, 1'b1);
    run(1'b0, 1'b0, -1, t0, b);
    n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise: got %b want 1", b); end
    n_vec++; if (done0_cnt !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", done0_cnt); end
    n_vec++; if (done0_cyc - t0 !== exp_cyc) begin n_err++; $display("FAIL basic_done_time: got %0d want %0d", done0_cyc - t0, exp_cyc); end
    n_vec++; if (busy_at_done0 !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done0); end
    n_vec++; if (cap0.size() !== 432) begin n_err++; $display("FAIL basic_plot_count: got %0d want 432", cap0.size()); end
    d = first_diff(1'b0);
    n_vec++; if (d !== -1) begin n_err++; $display("FAIL basic_stream: first diff at %0d (got %0d pixels want %0d)", d, cap0.size(), exp_q.size()); end
    if (cap0.size() > 0) begin
      n_vec++; if (cap0[0] !== {8'd40, 7'd40, 3'd3}) begin n_err++; $display("FAIL basic_first_pixel: got %h want %h", cap0[0], {8'd40, 7'd40, 3'd3}); end
      n_vec++; if (cap0[cap0.size()-1] !== {8'd77, 7'd80, 3'd3}) begin n_err++; $display("FAIL basic_last_pixel: got %h want %h", cap0[cap0.size()-1], {8'd77, 7'd80, 3'd3}); end
    end
  endtask

  task automatic test_erase;
    int t0, d; logic b;
    set_basic;
    model(tab0, 4, 1'b1, 1'b1);
    run(1'b0, 1'b1, -1, t0, b);
    d = first_diff(1'b0);
    n_vec++; if (d !== -1) begin n_err++; $display("FAIL erase_stream: first diff at %0d (got %0d pixels want %0d)", d, cap0.size(), exp_q.size()); end
    n_vec++; if (done0_cyc - t0 !== exp_cyc) begin n_err++; $display("FAIL erase_done_time: got %0d want %0d", done0_cyc - t0, exp_cyc); end
  endtask

  task automatic test_clip;
    int t0, d; logic b;
    rect_desc_t a[4];
    tab0[0] = mk(158, 118, 4, 4, 5);
    tab0[1] = mk(5, 5, 0, 0, 1);
    tab0[2] = mk(5, 5, 3, 0, 1);
    tab0[3] = mk(5, 5, 0, 3, 1);
    model(tab0, 4, 1'b0, 1'b1);
    run(1'b0, 1'b0, -1, t0, b);
    n_vec++; if (cap0.size() !== 4) begin n_err++; $display("FAIL clip_on_count: got %0d want 4", cap0.size()); end
    d = first_diff(1'b0);
    n_vec++; if (d !== -1) begin n_err++; $display("FAIL clip_on_stream: first diff at %0d", d); end
    n_vec++; if (done0_cyc - t0 !== exp_cyc) begin n_err++; $display("FAIL clip_on_done_time: got %0d want %0d", done0_cyc - t0, exp_cyc); end
    tab1[0] = mk(158, 118, 4, 4, 5);
    tab1[1] = mk(0, 0, 0, 0, 0);
    a[0] = tab1[0]; a[1] = tab1[1]; a[2] = tab1[1]; a[3] = tab1[1];
    model(a, 1, 1'b0, 1'b0);
    run(1'b1, 1'b0, -1, t0, b);
    n_vec++; if (cap1.size() !== 16) begin n_err++; $display("FAIL clip_off_count: got %0d want 16", cap1.size()); end
    d = first_diff(1'b1);
    n_vec++; if (d !== -1) begin n_err++; $display("FAIL clip_off_stream: first diff at %0d", d); end
    if (cap1.size() >= 4) begin
      n_vec++; if (cap1[3].x !== 8'd161) begin n_err++; $display("FAIL clip_off_wrap_x: got %0d want 161", cap1[3].x); end
    end
    n_vec++; if (done1_cyc - t0 !== exp_cyc) begin n_err++; $display("FAIL clip_off_done_time: got %0d want %0d", done1_cyc - t0, exp_cyc); end
  endtask

  task automatic test_hold;
    int t0, d; logic b;
    set_basic;
    model(tab0, 4, 1'b0, 1'b1);
    run(1'b0, 1'b0, 10, t0, b);
    d = first_diff(1'b0);
    n_vec++; if (d !== -1) begin n_err++; $display("FAIL hold_stream: first diff at %0d (got %0d pixels want %0d)", d, cap0.size(), exp_q.size()); end
    n_vec++; if (done0_cyc - t0 !== exp_cyc + 5) begin n_err++; $display("FAIL hold_done_time: got %0d want %0d", done0_cyc - t0, exp_cyc + 5); end
    n_vec++; if (done0_cnt !== 1) begin n_err++; $display("FAIL hold_done_count: got %0d want 1", done0_cnt); end
  endtask

  task automatic test_handshake;
    int t0, t1, k;
    set_basic;
    model(tab0, 4, 1'b0, 1'b1);
    cap0.delete(); done0_cnt = 0; erase = 1'b0;
    start = 1'b1; t0 = cyc; tick; start = 1'b0;
    repeat (30) tick;
    start = 1'b1; tick; start = 1'b0;
    for (k = 0; k < 20000 && done0 !== 1'b1; k++) tick;
    n_vec++; if (done0_cyc - t0 !== exp_cyc) begin n_err++; $display("FAIL busy_start_done_time: got %0d want %0d", done0_cyc - t0, exp_cyc); end
    n_vec++; if (done0_cnt !== 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d want 1", done0_cnt); end
    // Now in the done cycle: this request must be dropped.
    start = 1'b1; tick;
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL done_cycle_start: busy got %b want 0", busy0); end
    t1 = cyc; tick; start = 1'b0;
    n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL idle_start_accept: busy got %b want 1", busy0); end
    for (k = 0; k < 20000 && done0_cnt < 2; k++) tick;
    repeat (4) tick;
    n_vec++; if (done0_cyc - t1 !== exp_cyc) begin n_err++; $display("FAIL second_run_done_time: got %0d want %0d", done0_cyc - t1, exp_cyc); end
    n_vec++; if (cap0.size() !== 2 * exp_q.size()) begin n_err++; $display("FAIL two_run_plot_count: got %0d want %0d", cap0.size(), 2 * exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int t0, d; logic b;
    tab0[0] = mk(10, 20, 3, 2, 1);
    tab0[1] = mk(30, 5, 2, 2, 2);
    tab0[2] = mk(50, 60, 4, 3, 4);
    tab0[3] = mk(90, 100, 6, 5, 6);
    cap0.delete(); done0_cnt = 0; erase = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < 5000 && cap0.size() < 25; k++) tick;
    n_vec++; if (idx0 !== 2'd3) begin n_err++; $display("FAIL mid_reset_idx_before: got %0d want 3", idx0); end
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if ({plot0, x0, y0, col0, busy0, done0, idx0} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %b want all zero", {plot0, x0, y0, col0, busy0, done0, idx0});
    end
    repeat (2) tick;
    reset = 1'b0;
    repeat (30) tick;
    n_vec++; if (done0_cnt !== 0) begin n_err++; $display("FAIL mid_reset_no_done: got %0d want 0", done0_cnt); end
    model(tab0, 4, 1'b0, 1'b1);
    run(1'b0, 1'b0, -1, t0, b);
    d = first_diff(1'b0);
    n_vec++; if (d !== -1) begin n_err++; $display("FAIL after_reset_stream: first diff at %0d (got %0d pixels want %0d)", d, cap0.size(), exp_q.size()); end
    n_vec++; if (done0_cyc - t0 !== exp_cyc) begin n_err++; $display("FAIL after_reset_done_time: got %0d want %0d", done0_cyc - t0, exp_cyc); end
  endtask

  task automatic test_random;
    int t0, d; logic b; bit er;
    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < 4; r++)
        tab0[r] = mk($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 6),
                     $urandom_range(0, 5), $urandom_range(0, 7));
      er = 1'($urandom_range(0, 1));
      model(tab0, 4, er, 1'b1);
      run(1'b0, er, -1, t0, b);
      d = first_diff(1'b0);
      n_vec++; if (d !== -1) begin n_err++; $display("FAIL random_stream[%0d]: first diff at %0d (got %0d pixels want %0d)", it, d, cap0.size(), exp_q.size()); end
      n_vec++; if (done0_cyc - t0 !== exp_cyc) begin n_err++; $display("FAIL random_done_time[%0d]: got %0d want %0d", it, done0_cyc - t0, exp_cyc); end
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) tab0[r] = mk(0, 0, 0, 0, 0);
    tab1[0] = mk(0, 0, 0, 0, 0);
    tab1[1] = mk(0, 0, 0, 0, 0);
    test_reset;
    test_basic;
    test_erase;
    test_clip;
    test_hold;
    test_handshake;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
